hex_score_reader: RTL
=====================

Name: hex_score_reader

Overview:
- Decoder for the scoreboard's 7-segment digit chain. It takes the active-low segment patterns driven onto the HEX digits (0-9 encoding) and converts them back into a binary score.
- Digits are converted serially, most significant digit first, under a start/done handshake.
- Malformed patterns are flagged, and the best error-free score is tracked.
- Sits beside the score display chain; feeds game-over and high-score logic.

Parameters:
- NUM_DIGITS, 3, number of 7-bit digit patterns on segs (1..4).
- SCORE_W, 10, width of score/high_score; the accumulator wraps modulo 2^SCORE_W.

Ports:
- clk  input  1  system clock, all state on posedge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  request conversion; sampled only in IDLE.
- segs  input  7*NUM_DIGITS  digit patterns; digit k in segs[7k+6:7k], digit 0 least significant.
- busy  output  1  high from the cycle after start is accepted until DONE is exited.
- done  output  1  one-cycle pulse; score/error are valid and stable from that cycle on.
- score  output  SCORE_W  last converted value; held until the next DONE.
- error  output  1  last conversion saw at least one invalid pattern; held with score.
- high_score  output  SCORE_W  maximum error-free score since reset.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy=0, done=0, score=0, error=0, high_score=0; shadow, index and accumulator cleared. Reset mid-conversion abandons it with no done pulse.
- Pattern decode, active-low, bit order g..a:
  - 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0010000=9.
  - Blank 1111111 decodes to 0 without error.
  - Any other pattern decodes to 0 and sets the sticky err flag.
- FSM states IDLE, CONV, DONE:
  - IDLE: if start, capture segs into the shadow register, index=NUM_DIGITS-1, acc=0, err=0, then go to CONV. The capture makes later segs changes irrelevant.
  - CONV: each cycle, acc = acc*10 + decode(shadow digit[index]), truncated to SCORE_W. err |= invalid. If index==0, go to DONE; else index-1.
  - DONE: score<=acc, error<=err, done=1 for this cycle only. If !err and acc>high_score, high_score<=acc. Next state IDLE.
- Latency: start sampled at edge 0 gives done high during cycle NUM_DIGITS+1. Back-to-back starts are possible every NUM_DIGITS+2 cycles.
- start while busy or in DONE is ignored (not queued). Holding start high continuously restarts immediately on return to IDLE.
- busy is low in IDLE only.
- Overflow: with NUM_DIGITS=4 and SCORE_W=10, 9999 wraps to 9999 mod 1024 = 783. No flag is raised for wrap.
- Equal score does not rewrite high_score; an error conversion never updates it.

Optional Feature:
- Macro HEX_SCORE_HIGH_EN.
- Defined: high_score tracking as above.
- Undefined: no comparator or high_score register is built; high_score is tied to 0. All other behaviour is identical.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, released -> busy=0, done=0, score=0, error=0, high_score=0. Asserting reset mid-CONV returns these values in the same cycle.
- Digits {1,2,3}: segs = 1111001_0100100_0110000, start one cycle -> busy for 4 cycles, done pulse at cycle 4, score=123, error=0, high_score=123.
- Lower score after a higher one: digits {0,4,5} -> score=45, high_score stays 123. Then {9,9,9} -> score=999, high_score=999.
- Invalid pattern: middle digit 1010101 with outer digits 7 and 2 -> score=702, error=1, high_score unchanged. The next clean {0,0,1} -> error=0, score=1.
- Blank leading digits: 1111111_1111111_0010010 -> score=5, error=0.
- Capture and ignore: change segs and pulse start during CONV -> result reflects the captured value only; exactly one done pulse. A new start in the cycle after done is accepted.
- Repeat with HEX_SCORE_HIGH_EN undefined -> high_score=0 throughout, all scores as above.

Source files
------------

// File: rtl/hex_score_reader_if.sv
// Bus bundle for hex_score_reader: start/done handshake, the captured digit
// patterns, and the converted results. state_dbg mirrors the reader FSM.
//
// Handshake: the master raises start; the reader accepts it only while idle
// (busy low) and ignores it otherwise, with nothing queued. busy rises the
// cycle after acceptance and stays high until the result cycle has ended.
// done is a single-cycle pulse, and score/error are valid from that cycle
// until the next done.
interface hex_score_reader_if #(
  parameter int NUM_DIGITS = 3,
  parameter int SCORE_W    = 10
);
  logic                    start;
  logic [7*NUM_DIGITS-1:0] segs;
  logic                    busy;
  logic                    done;
  logic [SCORE_W-1:0]      score;
  logic                    error;
  logic [SCORE_W-1:0]      high_score;
  logic [1:0]              state_dbg;

  modport master (
    output start, segs,
    input  busy, done, score, error, high_score, state_dbg
  );

  modport slave (
    input  start, segs,
    output busy, done, score, error, high_score, state_dbg
  );
endinterface

// File: rtl/hex_score_reader.sv
// hex_score_reader: converts the active-low 7-segment patterns on the HEX
// digit chain back into a binary score. The digits are walked serially, most
// significant first. Malformed patterns raise a sticky error flag.
// Optional feature macro HEX_SCORE_HIGH_EN: when defined, the best error-free
// score since reset is tracked on high_score; otherwise high_score is tied to 0.
module hex_score_reader #(
  parameter int NUM_DIGITS = 3,
  parameter int SCORE_W    = 10
) (
  input logic               clk,
  input logic               reset,
  hex_score_reader_if.slave bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SLOTS = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [7*NUM_DIGITS-1:0] shadow_q;
  logic [IDX_W-1:0]        idx_q;
  logic [SCORE_W-1:0]      acc_q;
  logic                    err_q;
  logic [SCORE_W-1:0]      score_q;
  logic                    error_q;

  logic                    load;
  logic                    step;
  logic                    last;

  logic [6:0]              digit [SLOTS];
  logic [6:0]              cur_pat;
  logic [3:0]              cur_val;
  logic                    cur_bad;
  logic [SCORE_W-1:0]      acc_x10;
  logic [SCORE_W-1:0]      acc_next;
  logic                    err_next;

  // Split the shadow into digit slots. Slots beyond NUM_DIGITS read as blank
  // so every index value selects a defined pattern.
  for (genvar k = 0; k < SLOTS; k++) begin : g_slot
    if (k < NUM_DIGITS) begin : g_real
      assign digit[k] = shadow_q[7*k +: 7];
    end else begin : g_pad
      assign digit[k] = 7'b1111111;
    end
  end

  assign cur_pat = digit[idx_q];

  // Decode one active-low pattern (bit order g..a); blank is a valid 0.
  always_comb begin
    cur_val = 4'd0;
    cur_bad = 1'b0;
    case (cur_pat)
      7'b1000000: cur_val = 4'd0;
      7'b1111001: cur_val = 4'd1;
      7'b0100100: cur_val = 4'd2;
      7'b0110000: cur_val = 4'd3;
      7'b0011001: cur_val = 4'd4;
      7'b0010010: cur_val = 4'd5;
      7'b0000010: cur_val = 4'd6;
      7'b1111000: cur_val = 4'd7;
      7'b0000000: cur_val = 4'd8;
      7'b0010000: cur_val = 4'd9;
      7'b1111111: cur_val = 4'd0;
      default:    cur_bad = 1'b1;
    endcase
  end

  // Horner step: acc*10 + digit, wrapping modulo 2^SCORE_W without a flag.
  always_comb begin
    acc_x10  = (acc_q << 3) + (acc_q << 1);
    acc_next = acc_x10 + SCORE_W'(cur_val);
    err_next = err_q | cur_bad;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and datapath controls; start is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        step = 1'b1;
        if (idx_q == '0) begin
          last    = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Capture the digits at acceptance, then walk them from the top index down.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
      err_q    <= 1'b0;
    end else if (load) begin
      shadow_q <= bus.segs;
      idx_q    <= LAST_IDX;
      acc_q    <= '0;
      err_q    <= 1'b0;
    end else if (step) begin
      acc_q <= acc_next;
      err_q <= err_next;
      if (!last) begin
        idx_q <= idx_q - 1'b1;
      end
    end
  end

  // Publish the result on entry to DONE so it is already valid in the done cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score_q <= '0;
      error_q <= 1'b0;
    end else if (last) begin
      score_q <= acc_next;
      error_q <= err_next;
    end
  end

`ifdef HEX_SCORE_HIGH_EN
  logic [SCORE_W-1:0] high_q;

  // Keep the best clean score; equal values and error results leave it alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      high_q <= '0;
    end else if (last && !err_next && (acc_next > high_q)) begin
      high_q <= acc_next;
    end
  end

  assign bus.high_score = high_q;
`else
  assign bus.high_score = '0;
`endif

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.score     = score_q;
  assign bus.error     = error_q;
  assign bus.state_dbg = state_q;

endmodule
